// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one unified memory port between instruction fetch
// and the EX/MEM data requester. One grant at a time, request held stable
// until memReady, one-cycle valid pulses back to the requesters, fetch
// cancellation on flush, and a bound on fetch starvation.
//
// Handshake semantics: requesters hold their level request (fetchReq,
// dataRead/dataWrite) with stable address/data until their one-cycle valid
// pulse; during that valid cycle the same requester is masked from a new
// grant. On the memory side memReq and its payload are registered and stay
// constant until the cycle memReady is sampled high; memRData is only
// consumed in that cycle.
module mem_port_arbiter #(
    parameter int width     = 32,
    parameter int starveMax = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fetchReq,
    input  logic [width-1:0] fetchAddr,
    input  logic             fetchFlush,
    output logic             fetchValid,
    output logic [width-1:0] fetchData,
    input  logic             dataRead,
    input  logic             dataWrite,
    input  logic [width-1:0] dataAddr,
    input  logic [2:0]       dataMode,
    input  logic [width-1:0] dataWData,
    output logic             dataValid,
    output logic [width-1:0] dataRData,
    output logic             stallOut,
    output logic             memReq,
    output logic             memWrite,
    output logic [width-1:0] memAddr,
    output logic [2:0]       memMode,
    output logic [width-1:0] memWData,
    input  logic             memReady,
    input  logic [width-1:0] memRData,
    output logic [1:0]       dbgState
);

    localparam int cnt_w = $clog2(starveMax + 1);
    localparam logic [cnt_w-1:0] starve_limit = cnt_w'(starveMax);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        FETCH = 2'd2,
        DROP  = 2'd3
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [cnt_w-1:0] starve_cnt;
    logic             data_elig;
    logic             fetch_elig;
    logic             grant_data;
    logic             grant_fetch;

    // A requester whose valid pulse is out this cycle is not re-granted yet.
    assign data_elig  = (dataRead | dataWrite) & ~dataValid;
    assign fetch_elig = fetchReq & ~fetchValid & ~fetchFlush;
    assign stallOut   = (dataRead | dataWrite) & ~dataValid;
    assign dbgState   = state;

    // Grant decision and next-state selection.
    always_comb begin
        next_state  = state;
        grant_data  = 1'b0;
        grant_fetch = 1'b0;
        case (state)
            IDLE: begin
                if (data_elig && (!fetch_elig || starve_cnt < starve_limit)) begin
                    grant_data = 1'b1;
                    next_state = DATA;
                end else if (fetch_elig) begin
                    grant_fetch = 1'b1;
                    next_state  = FETCH;
                end
            end
            DATA: begin
                if (memReady) next_state = IDLE;
            end
            FETCH: begin
                // A flush with no ack yet must still wait out the memory access.
                if (memReady)        next_state = IDLE;
                else if (fetchFlush) next_state = DROP;
            end
            DROP: begin
                if (memReady) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Memory-port request registers, response registers and starvation counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            memReq     <= 1'b0;
            memWrite   <= 1'b0;
            memAddr    <= '0;
            memMode    <= 3'h0;
            memWData   <= '0;
            fetchValid <= 1'b0;
            fetchData  <= '0;
            dataValid  <= 1'b0;
            dataRData  <= '0;
            starve_cnt <= '0;
        end else begin
            fetchValid <= 1'b0;
            dataValid  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_data) begin
                        memReq     <= 1'b1;
                        memWrite   <= dataWrite;
                        memAddr    <= dataAddr;
                        memMode    <= dataMode;
                        memWData   <= dataWData;
                        // Count only data grants that jumped ahead of a waiting fetch.
                        starve_cnt <= fetch_elig ? starve_cnt + cnt_w'(1) : '0;
                    end else if (grant_fetch) begin
                        memReq     <= 1'b1;
                        memWrite   <= 1'b0;
                        memAddr    <= fetchAddr;
                        memMode    <= 3'h2;
                        starve_cnt <= '0;
                    end else begin
                        memReq <= 1'b0;
                    end
                end
                DATA: begin
                    if (memReady) begin
                        memReq    <= 1'b0;
                        dataValid <= 1'b1;
                        if (!memWrite) dataRData <= memRData;
                    end
                end
                FETCH: begin
                    if (memReady) begin
                        memReq <= 1'b0;
                        if (!fetchFlush) begin
                            fetchValid <= 1'b1;
                            fetchData  <= memRData;
                        end
                    end
                end
                DROP: begin
                    if (memReady) memReq <= 1'b0;
                end
                default: memReq <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scoreboard bench for mem_port_arbiter.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        fetchReq;
    logic [31:0] fetchAddr;
    logic        fetchFlush;
    logic        fetchValid;
    logic [31:0] fetchData;
    logic        dataRead;
    logic        dataWrite;
    logic [31:0] dataAddr;
    logic [2:0]  dataMode;
    logic [31:0] dataWData;
    logic        dataValid;
    logic [31:0] dataRData;
    logic        stallOut;
    logic        memReq;
    logic        memWrite;
    logic [31:0] memAddr;
    logic [2:0]  memMode;
    logic [31:0] memWData;
    logic        memReady;
    logic [31:0] memRData;
    logic [1:0]  dbgState;

    int checks   = 0;
    int failures = 0;
    int mem_wait = 0;
    int mem_cnt  = 0;

    // grant entry: {check_wdata, write, mode, addr, wdata}
    logic [68:0] exp_grant_q[$];
    logic [31:0] exp_data_q[$];
    logic [31:0] exp_fetch_q[$];

    logic        prev_req = 1'b0;
    logic        prev_dv  = 1'b0;
    logic        prev_fv  = 1'b0;
    logic [67:0] prev_bus = '0;

    mem_port_arbiter #(.width(32), .starveMax(4)) dut (
        .clk(clk), .rst(rst),
        .fetchReq(fetchReq), .fetchAddr(fetchAddr), .fetchFlush(fetchFlush),
        .fetchValid(fetchValid), .fetchData(fetchData),
        .dataRead(dataRead), .dataWrite(dataWrite), .dataAddr(dataAddr),
        .dataMode(dataMode), .dataWData(dataWData),
        .dataValid(dataValid), .dataRData(dataRData), .stallOut(stallOut),
        .memReq(memReq), .memWrite(memWrite), .memAddr(memAddr),
        .memMode(memMode), .memWData(memWData),
        .memReady(memReady), .memRData(memRData),
        .dbgState(dbgState)
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [68:0] act, input logic [68:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [68:0] g(input logic chk, input logic wr, input logic [2:0] mode,
                                      input logic [31:0] addr, input logic [31:0] wdata);
        return {chk, wr, mode, addr, wdata};
    endfunction

    // memory model: fixed read data per address, mem_wait extra cycles per access
    function automatic logic [31:0] rdata_for(input logic [31:0] addr);
        case (addr)
            32'h100: return 32'hDEADBEEF;
            32'h040: return 32'h00000013;
            32'h080: return 32'h12345678;
            default: return {addr[15:0], 16'hC0DE};
        endcase
    endfunction

    always @(negedge clk) begin
        if (memReq) begin
            if (mem_cnt == mem_wait) begin
                memReady = 1'b1;
                memRData = rdata_for(memAddr);
            end else begin
                memReady = 1'b0;
                memRData = 32'hBAD0BAD0;
            end
            mem_cnt++;
        end else begin
            memReady = 1'b0;
            memRData = 32'hBAD0BAD0;
            mem_cnt  = 0;
        end
    end

    // monitor: grants, bus stability, valid pulses
    always @(negedge clk) begin
        logic [68:0] e;
        logic [67:0] act;
        logic [67:0] exp;
        if (!rst) begin
            if (memReq && !prev_req) begin
                act = {memWrite, memMode, memAddr, memWData};
                if (exp_grant_q.size() == 0) begin
                    check("grant_unexpected", 69'(1), 69'(0));
                end else begin
                    e   = exp_grant_q.pop_front();
                    exp = e[67:0];
                    if (!e[68]) begin
                        act[31:0] = '0;
                        exp[31:0] = '0;
                    end
                    check("grant", 69'(act), 69'(exp));
                end
            end
            if (memReq && prev_req)
                check("mem_stable", 69'({memWrite, memMode, memAddr, memWData}), 69'(prev_bus));
            if (dataValid) begin
                check("data_pulse_len", 69'(prev_dv), 69'(0));
                if (exp_data_q.size() == 0) check("data_unexpected", 69'(1), 69'(0));
                else check("data_rdata", 69'(dataRData), 69'(exp_data_q.pop_front()));
            end
            if (fetchValid) begin
                check("fetch_pulse_len", 69'(prev_fv), 69'(0));
                if (exp_fetch_q.size() == 0) check("fetch_unexpected", 69'(1), 69'(0));
                else check("fetch_data", 69'(fetchData), 69'(exp_fetch_q.pop_front()));
            end
        end
        prev_req = memReq;
        prev_bus = {memWrite, memMode, memAddr, memWData};
        prev_dv  = dataValid;
        prev_fv  = fetchValid;
    end

    // driver tasks (call at a negedge)
    task automatic data_access(input logic wr, input logic [31:0] addr, input logic [2:0] mode,
                               input logic [31:0] wdata, input logic [31:0] exp_rdata);
        logic got;
        got       = 1'b0;
        dataRead  = ~wr;
        dataWrite = wr;
        dataAddr  = addr;
        dataMode  = mode;
        dataWData = wdata;
        exp_data_q.push_back(exp_rdata);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (dataValid) begin
                got = 1'b1;
                break;
            end
        end
        check("data_done", 69'(got), 69'(1));
    endtask

    task automatic data_idle();
        dataRead  = 1'b0;
        dataWrite = 1'b0;
    endtask

    task automatic fetch_access(input logic [31:0] addr, input logic [31:0] exp_data);
        logic got;
        got       = 1'b0;
        fetchReq  = 1'b1;
        fetchAddr = addr;
        exp_fetch_q.push_back(exp_data);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (fetchValid) begin
                got = 1'b1;
                break;
            end
        end
        check("fetch_done", 69'(got), 69'(1));
        fetchReq = 1'b0;
    endtask

    task automatic wait_memreq(input string name);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (memReq) begin
                got = 1'b1;
                break;
            end
        end
        check(name, 69'(got), 69'(1));
    endtask

    task automatic check_reset_outputs(input string p);
        check({p, "_ctrl"},  69'({memReq, memWrite, fetchValid, dataValid, memMode}), 69'(0));
        check({p, "_maddr"}, 69'(memAddr), 69'(0));
        check({p, "_mwdata"}, 69'(memWData), 69'(0));
        check({p, "_fdata"}, 69'(fetchData), 69'(0));
        check({p, "_rdata"}, 69'(dataRData), 69'(0));
        check({p, "_state"}, 69'(dbgState), 69'(0));
    endtask

    initial begin
        rst        = 1'b1;
        fetchReq   = 1'b0;
        fetchAddr  = '0;
        fetchFlush = 1'b0;
        dataRead   = 1'b0;
        dataWrite  = 1'b0;
        dataAddr   = '0;
        dataMode   = '0;
        dataWData  = '0;
        memReady   = 1'b0;
        memRData   = '0;

        // reset state
        repeat (2) @(negedge clk);
        check_reset_outputs("init_rst");
        check("init_stall", 69'(stallOut), 69'(0));
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // load 0x100, memory 2 cycles late: memReq cycles 1-3, valid cycle 4
        exp_grant_q.push_back(g(1'b1, 1'b0, 3'h2, 32'h100, 32'h0));
        exp_data_q.push_back(32'hDEADBEEF);
        mem_wait  = 2;
        dataRead  = 1'b1;
        dataAddr  = 32'h100;
        dataMode  = 3'h2;
        dataWData = 32'h0;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            check($sformatf("load_c%0d_stall", c), 69'(stallOut), 69'(c <= 3));
            check($sformatf("load_c%0d_memreq", c), 69'(memReq), 69'(c >= 1 && c <= 3));
            check($sformatf("load_c%0d_valid", c), 69'(dataValid), 69'(c == 4));
        end
        data_idle();
        @(negedge clk);

        // simultaneous store and fetch, zero-wait: store first, dataRData unchanged
        mem_wait = 0;
        exp_grant_q.push_back(g(1'b1, 1'b1, 3'h2, 32'h200, 32'h55));
        exp_grant_q.push_back(g(1'b0, 1'b0, 3'h2, 32'h040, 32'h0));
        fork
            begin
                data_access(1'b1, 32'h200, 3'h2, 32'h55, 32'hDEADBEEF);
                data_idle();
            end
            fetch_access(32'h040, 32'h00000013);
        join
        @(negedge clk);

        // starvation bound: fetch pending and masked by a flush in each data-valid
        // cycle, so it stays eligible at every data grant: D,D,D,D,F,D
        exp_grant_q.push_back(g(1'b1, 1'b0, 3'h2, 32'h400, 32'h0));
        exp_grant_q.push_back(g(1'b1, 1'b0, 3'h2, 32'h404, 32'h0));
        exp_grant_q.push_back(g(1'b1, 1'b0, 3'h2, 32'h408, 32'h0));
        exp_grant_q.push_back(g(1'b1, 1'b0, 3'h2, 32'h40C, 32'h0));
        exp_grant_q.push_back(g(1'b0, 1'b0, 3'h2, 32'h080, 32'h0));
        exp_grant_q.push_back(g(1'b1, 1'b0, 3'h2, 32'h410, 32'h0));
        fork
            begin
                data_access(1'b0, 32'h400, 3'h2, 32'h0, 32'h0400C0DE);
                data_access(1'b0, 32'h404, 3'h2, 32'h0, 32'h0404C0DE);
                data_access(1'b0, 32'h408, 3'h2, 32'h0, 32'h0408C0DE);
                data_access(1'b0, 32'h40C, 3'h2, 32'h0, 32'h040CC0DE);
                data_access(1'b0, 32'h410, 3'h2, 32'h0, 32'h0410C0DE);
                data_idle();
            end
            begin
                int flushes;
                logic got;
                flushes   = 0;
                got       = 1'b0;
                fetchReq  = 1'b1;
                fetchAddr = 32'h080;
                exp_fetch_q.push_back(32'h12345678);
                for (int i = 0; i < 200; i++) begin
                    @(negedge clk);
                    fetchFlush = 1'b0;
                    if (fetchValid) begin
                        got = 1'b1;
                        break;
                    end
                    if (dataValid && flushes < 4) begin
                        fetchFlush = 1'b1;
                        flushes++;
                    end
                end
                check("starve_fetch_done", 69'(got), 69'(1));
                check("starve_flushes", 69'(flushes), 69'(4));
                fetchReq = 1'b0;
            end
        join
        @(negedge clk);

        // flush before memReady: DROP, memReq held, no fetchValid
        mem_wait = 3;
        exp_grant_q.push_back(g(1'b0, 1'b0, 3'h2, 32'h084, 32'h0));
        fetchReq  = 1'b1;
        fetchAddr = 32'h084;
        wait_memreq("drop_memreq_seen");
        fetchFlush = 1'b1;
        fetchReq   = 1'b0;
        @(negedge clk);
        fetchFlush = 1'b0;
        #1;
        check("drop_state", 69'(dbgState), 69'(3));
        check("drop_req_k1", 69'(memReq), 69'(1));
        @(negedge clk);
        #1;
        check("drop_req_k2", 69'(memReq), 69'(1));
        @(negedge clk);
        #1;
        check("drop_req_k3", 69'(memReq), 69'(1));
        @(negedge clk);
        #1;
        check("drop_req_k4", 69'(memReq), 69'(0));
        check("drop_state_idle", 69'(dbgState), 69'(0));
        check("drop_no_valid", 69'(fetchValid), 69'(0));
        check("drop_fdata_kept", 69'(fetchData), 69'(32'h12345678));
        @(negedge clk);

        // memReady and fetchFlush in the same FETCH cycle: IDLE, no pulse
        mem_wait = 0;
        exp_grant_q.push_back(g(1'b0, 1'b0, 3'h2, 32'h088, 32'h0));
        fetchReq  = 1'b1;
        fetchAddr = 32'h088;
        wait_memreq("rdyflush_memreq_seen");
        fetchFlush = 1'b1;
        fetchReq   = 1'b0;
        @(negedge clk);
        fetchFlush = 1'b0;
        #1;
        check("rdyflush_state", 69'(dbgState), 69'(0));
        check("rdyflush_req", 69'(memReq), 69'(0));
        check("rdyflush_no_valid", 69'(fetchValid), 69'(0));
        check("rdyflush_fdata_kept", 69'(fetchData), 69'(32'h12345678));
        repeat (2) @(negedge clk);

        // reset mid-DATA: outputs clear at once, no dataValid afterwards
        mem_wait = 5;
        exp_grant_q.push_back(g(1'b1, 1'b0, 3'h4, 32'h300, 32'h0));
        dataRead  = 1'b1;
        dataAddr  = 32'h300;
        dataMode  = 3'h4;
        dataWData = 32'h0;
        wait_memreq("rst_memreq_seen");
        check("rst_pre_rdata", 69'(dataRData), 69'(32'h0410C0DE));
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_rst");
        @(negedge clk);
        data_idle();
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        check("post_rst_req", 69'(memReq), 69'(0));
        check("post_rst_state", 69'(dbgState), 69'(0));

        check("grant_q_empty", 69'(exp_grant_q.size()), 69'(0));
        check("data_q_empty", 69'(exp_data_q.size()), 69'(0));
        check("fetch_q_empty", 69'(exp_fetch_q.size()), 69'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
